// File: rtl/avmm_mux_pkg.sv
// Shared types and constants for the 1-to-N Avalon-MM mux.
package avmm_mux_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FWD,
        ST_ACK,
        ST_RDV,
        ST_ERR
    } state_t;

    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
    localparam int unsigned CNT_W        = 16;
    localparam int unsigned ERR_CNT_W    = 8;

    function automatic int unsigned sel_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/avmm_mux_timer.sv
// Transaction watchdog: counts enabled cycles, flags the TIMEOUT-th one.
module avmm_mux_timer
    import avmm_mux_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic clk,
    input  logic reset_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

    // Fires on the cycle that completes TIMEOUT enabled cycles
    assign o_expired_c = i_en && (r_cnt == CNT_W'(TIMEOUT - 1));

endmodule

// File: rtl/avmm_mux_1ton.sv
// One Avalon-MM host fanned out to N_AGENTS agents by address window; a single outstanding
// transaction with timeout abort, decode-error response and a saturating error counter.
module avmm_mux_1ton
    import avmm_mux_pkg::*;
#(
    parameter int unsigned       N_AGENTS = 4,
    parameter int unsigned       ADDR_W   = 16,
    parameter int unsigned       DATA_W   = 32,
    parameter int unsigned       SEL_LSB  = 12,
    parameter int unsigned       TIMEOUT  = 255,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic [ADDR_W-1:0]          h_address,
    input  logic                       h_read,
    input  logic                       h_write,
    input  logic [DATA_W-1:0]          h_writedata,
    input  logic [DATA_W/8-1:0]        h_byteenable,
    output logic                       h_waitrequest,
    output logic [DATA_W-1:0]          h_readdata,
    output logic                       h_readdatavalid,
    output logic [N_AGENTS*ADDR_W-1:0] a_address,
    output logic [N_AGENTS-1:0]        a_read,
    output logic [N_AGENTS-1:0]        a_write,
    output logic [DATA_W-1:0]          a_writedata,
    output logic [DATA_W/8-1:0]        a_byteenable,
    input  logic [N_AGENTS-1:0]        a_waitrequest,
    input  logic [N_AGENTS*DATA_W-1:0] a_readdata,
    input  logic [N_AGENTS-1:0]        a_readdatavalid,
    output logic                       timeout_err,
    output logic [ERR_CNT_W-1:0]       err_cnt
);

    localparam int unsigned BE_W  = DATA_W / 8;
    localparam int unsigned SEL_W = sel_width(N_AGENTS);
    localparam int unsigned WIN_W = ADDR_W - SEL_LSB;

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_addr;
    logic [DATA_W-1:0]     r_wdata;
    logic [BE_W-1:0]       r_be;
    logic                  r_write;
    logic [SEL_W-1:0]      r_sel;
    logic [N_AGENTS-1:0]   r_a_read, r_a_write, w_a_read_nxt, w_a_write_nxt;
    logic                  r_h_wait, w_h_wait_nxt;
    logic                  r_h_rdv, w_h_rdv_nxt;
    logic [DATA_W-1:0]     r_h_rdata, w_h_rdata_nxt;
    logic                  r_tmo, w_tmo_nxt;
    logic [ERR_CNT_W-1:0]  r_err_cnt;
    logic                  w_err_inc, w_latch;
    logic [WIN_W-1:0]      w_win;
    logic [SEL_W-1:0]      w_sel;
    logic                  w_hit;
    logic [N_AGENTS-1:0]   w_sel_oh, w_r_sel_oh;
    logic [DATA_W-1:0]     w_rdata [N_AGENTS];
    logic                  w_run, w_expired;

    // The whole window above SEL_LSB is decoded, so addresses past the last agent fault
    assign w_win      = h_address[ADDR_W-1:SEL_LSB];
    assign w_sel      = w_win[SEL_W-1:0];
    assign w_hit      = ({1'b0, w_win} < (WIN_W+1)'(N_AGENTS));
    assign w_sel_oh   = N_AGENTS'(1) << w_sel;
    assign w_r_sel_oh = N_AGENTS'(1) << r_sel;
    assign w_run      = (r_state == ST_FWD) || (r_state == ST_RDV);

    genvar g;
    for (g = 0; g < N_AGENTS; g++) begin : g_rdata
        assign w_rdata[g] = a_readdata[g*DATA_W +: DATA_W];
    end

    avmm_mux_timer #(
        .TIMEOUT     (TIMEOUT)
    ) u_timer (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_clr       (!w_run),
        .i_en        (w_run),
        .o_expired_c (w_expired)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_a_read_nxt  = '0;
        w_a_write_nxt = '0;
        w_h_wait_nxt  = 1'b1;
        w_h_rdv_nxt   = 1'b0;
        w_h_rdata_nxt = r_h_rdata;
        w_tmo_nxt     = 1'b0;
        w_err_inc     = 1'b0;
        w_latch       = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (h_read || h_write) begin
                    w_latch = 1'b1;
                    if (w_hit) begin
                        w_state_nxt = ST_FWD;
                        if (h_write) w_a_write_nxt = w_sel_oh;
                        else         w_a_read_nxt  = w_sel_oh;
                    end else begin
                        w_state_nxt  = ST_ERR;
                        w_h_wait_nxt = 1'b0;
                        w_err_inc    = 1'b1;
                    end
                end
            end
            ST_FWD: begin
                if (!a_waitrequest[r_sel]) begin
                    w_state_nxt  = ST_ACK;
                    w_h_wait_nxt = 1'b0;
                end else if (w_expired) begin
                    w_state_nxt  = ST_ERR;
                    w_h_wait_nxt = 1'b0;
                    w_tmo_nxt    = 1'b1;
                    w_err_inc    = 1'b1;
                end else if (r_write) begin
                    w_a_write_nxt = w_r_sel_oh;
                end else begin
                    w_a_read_nxt = w_r_sel_oh;
                end
            end
            ST_ACK: begin
                w_state_nxt = r_write ? ST_IDLE : ST_RDV;
            end
            ST_RDV: begin
                if (a_readdatavalid[r_sel]) begin
                    w_state_nxt   = ST_IDLE;
                    w_h_rdv_nxt   = 1'b1;
                    w_h_rdata_nxt = w_rdata[r_sel];
                end else if (w_expired) begin
                    w_state_nxt   = ST_IDLE;
                    w_h_rdv_nxt   = 1'b1;
                    w_h_rdata_nxt = ERR_DATA;
                    w_tmo_nxt     = 1'b1;
                    w_err_inc     = 1'b1;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_IDLE;
                if (!r_write) begin
                    w_h_rdv_nxt   = 1'b1;
                    w_h_rdata_nxt = ERR_DATA;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Request capture; write takes priority when both strobes are high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_addr  <= '0;
            r_wdata <= '0;
            r_be    <= '0;
            r_write <= 1'b0;
            r_sel   <= '0;
        end else if (w_latch) begin
            r_addr  <= h_address;
            r_wdata <= h_writedata;
            r_be    <= h_byteenable;
            r_write <= h_write;
            r_sel   <= w_sel;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_a_read  <= '0;
            r_a_write <= '0;
            r_h_wait  <= 1'b1;
            r_h_rdv   <= 1'b0;
            r_h_rdata <= '0;
            r_tmo     <= 1'b0;
            r_err_cnt <= '0;
        end else begin
            r_a_read  <= w_a_read_nxt;
            r_a_write <= w_a_write_nxt;
            r_h_wait  <= w_h_wait_nxt;
            r_h_rdv   <= w_h_rdv_nxt;
            r_h_rdata <= w_h_rdata_nxt;
            r_tmo     <= w_tmo_nxt;
            if (w_err_inc && (r_err_cnt != '1)) begin
                r_err_cnt <= r_err_cnt + ERR_CNT_W'(1);
            end
        end
    end

    assign h_waitrequest   = r_h_wait;
    assign h_readdata      = r_h_rdata;
    assign h_readdatavalid = r_h_rdv;
    assign a_address       = {N_AGENTS{r_addr}};
    assign a_read          = r_a_read;
    assign a_write         = r_a_write;
    assign a_writedata     = r_wdata;
    assign a_byteenable    = r_be;
    assign timeout_err     = r_tmo;
    assign err_cnt         = r_err_cnt;

endmodule

// File: tb/tb_avmm_mux_1ton.sv
// Directed bench for avmm_mux_1ton: behavioural agents with programmable stall and read latency.
module tb_avmm_mux_1ton;

    localparam int unsigned NA = 4;

    logic         clk     = 1'b0;
    logic         reset_n = 1'b0;
    logic [15:0]  h_address    = '0;
    logic         h_read       = 1'b0;
    logic         h_write      = 1'b0;
    logic [31:0]  h_writedata  = '0;
    logic [3:0]   h_byteenable = '0;
    logic         h_waitrequest;
    logic [31:0]  h_readdata;
    logic         h_readdatavalid;
    logic [63:0]  a_address;
    logic [3:0]   a_read;
    logic [3:0]   a_write;
    logic [31:0]  a_writedata;
    logic [3:0]   a_byteenable;
    logic [3:0]   a_waitrequest;
    logic [127:0] a_readdata;
    logic [3:0]   a_readdatavalid;
    logic         timeout_err;
    logic [7:0]   err_cnt;

    int           stall [NA];
    int           lat   [NA];
    logic [31:0]  rd    [NA];
    logic [3:0]   inj = '0;
    logic [3:0]   wr_q = '1;
    logic [3:0]   rdv_q = '0;
    int           wcnt     [NA];
    int           rdv_pend [NA];
    logic [31:0]  wcap_data [NA];
    logic [31:0]  wcap_addr [NA];
    logic [3:0]   wcap_be   [NA];
    int           wstb [NA];
    int           rstb [NA];
    int           rdv_total = 0;
    int           tmo_total = 0;
    int           n_checks  = 0;
    int           n_fails   = 0;

    always #5 clk = ~clk;

    avmm_mux_1ton #(
        .N_AGENTS (4),
        .ADDR_W   (16),
        .DATA_W   (32),
        .SEL_LSB  (12),
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .h_address       (h_address),
        .h_read          (h_read),
        .h_write         (h_write),
        .h_writedata     (h_writedata),
        .h_byteenable    (h_byteenable),
        .h_waitrequest   (h_waitrequest),
        .h_readdata      (h_readdata),
        .h_readdatavalid (h_readdatavalid),
        .a_address       (a_address),
        .a_read          (a_read),
        .a_write         (a_write),
        .a_writedata     (a_writedata),
        .a_byteenable    (a_byteenable),
        .a_waitrequest   (a_waitrequest),
        .a_readdata      (a_readdata),
        .a_readdatavalid (a_readdatavalid),
        .timeout_err     (timeout_err),
        .err_cnt         (err_cnt)
    );

    assign a_waitrequest   = wr_q;
    assign a_readdatavalid = rdv_q | inj;
    assign a_readdata      = {rd[3], rd[2], rd[1], rd[0]};

    // Agent model: waitrequest held for stall[i] strobe cycles, readdatavalid lat[i] cycles after accept
    always @(negedge clk) begin
        for (int i = 0; i < NA; i++) begin
            rdv_q[i] = 1'b0;
            if (rdv_pend[i] > 0) begin
                rdv_pend[i] = rdv_pend[i] - 1;
                if (rdv_pend[i] == 0) rdv_q[i] = 1'b1;
            end
            if (a_read[i] || a_write[i]) begin
                wr_q[i] = (wcnt[i] < stall[i]);
                wcnt[i] = wcnt[i] + 1;
                if (!wr_q[i]) begin
                    if (a_write[i]) begin
                        wcap_data[i] = a_writedata;
                        wcap_addr[i] = 32'(a_address[i*16 +: 16]);
                        wcap_be[i]   = a_byteenable;
                    end else begin
                        rdv_pend[i] = lat[i];
                    end
                end
            end else begin
                wcnt[i] = 0;
                wr_q[i] = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        for (int i = 0; i < NA; i++) begin
            if (a_write[i]) wstb[i] = wstb[i] + 1;
            if (a_read[i])  rstb[i] = rstb[i] + 1;
        end
        if (h_readdatavalid) rdv_total = rdv_total + 1;
        if (timeout_err)     tmo_total = tmo_total + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic int tot_stb();
        int s = 0;
        for (int i = 0; i < NA; i++) s += wstb[i] + rstb[i];
        return s;
    endfunction

    task automatic host_write(input logic [15:0] addr, input logic [31:0] data,
                              input logic [3:0] be, output int acc);
        @(posedge clk); #1;
        h_address = addr; h_writedata = data; h_byteenable = be; h_write = 1'b1;
        acc = 999;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (!h_waitrequest) begin acc = n; break; end
        end
        @(posedge clk); #1;
        h_write = 1'b0;
    endtask

    task automatic host_read(input logic [15:0] addr, output int acc, output int dly,
                             output logic [31:0] data);
        @(posedge clk); #1;
        h_address = addr; h_read = 1'b1;
        acc = 999; dly = 999; data = '0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (!h_waitrequest) begin acc = n; break; end
        end
        @(posedge clk); #1;
        h_read = 1'b0;
        for (int n = 1; n <= 64; n++) begin
            @(negedge clk);
            if (h_readdatavalid) begin dly = n; data = h_readdata; break; end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int acc, dly, st0, r0, t0, w0;
        logic [31:0] rdat;
        for (int i = 0; i < NA; i++) begin
            stall[i] = 0; lat[i] = 2; rd[i] = 32'h0; wcnt[i] = 0; rdv_pend[i] = 0;
            wstb[i] = 0; rstb[i] = 0; wcap_data[i] = '0; wcap_addr[i] = '0; wcap_be[i] = '0;
        end
        rd[0] = 32'h0000_0BAD;

        repeat (2) @(negedge clk);
        check_eq("rst_waitrequest", 32'(h_waitrequest), 32'h1);
        check_eq("rst_rdv", 32'(h_readdatavalid), 32'h0);
        check_eq("rst_rdata", h_readdata, 32'h0);
        check_eq("rst_strobes", 32'({a_read, a_write}), 32'h0);
        check_eq("rst_err_cnt", 32'(err_cnt), 32'h0);
        check_eq("rst_timeout_err", 32'(timeout_err), 32'h0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // Write, agent 2 never stalls
        st0 = tot_stb(); w0 = wstb[2]; r0 = rdv_total;
        host_write(16'h2010, 32'h1234_5678, 4'hF, acc);
        repeat (3) @(negedge clk);
        check_eq("wr_accept_lat", 32'(acc), 32'd3);
        check_eq("wr_strobe_cycles", 32'(wstb[2] - w0), 32'd1);
        check_eq("wr_total_strobes", 32'(tot_stb() - st0), 32'd1);
        check_eq("wr_agent_data", wcap_data[2], 32'h1234_5678);
        check_eq("wr_agent_addr", wcap_addr[2], 32'h0000_2010);
        check_eq("wr_agent_be", 32'(wcap_be[2]), 32'hF);
        check_eq("wr_no_rdv", 32'(rdv_total - r0), 32'd0);

        // Read, agent 3 stalls 5 cycles, data 2 cycles after its accept
        stall[3] = 5; lat[3] = 2; rd[3] = 32'hA5A5_0001;
        st0 = tot_stb(); w0 = rstb[3]; r0 = rdv_total; t0 = tmo_total;
        host_read(16'h3004, acc, dly, rdat);
        repeat (6) @(negedge clk);
        check_eq("rd3_accept_lat", 32'(acc), 32'd8);
        check_eq("rd3_rdv_delay", 32'(dly), 32'd2);
        check_eq("rd3_data", rdat, 32'hA5A5_0001);
        check_eq("rd3_rdv_once", 32'(rdv_total - r0), 32'd1);
        check_eq("rd3_strobe_cycles", 32'(rstb[3] - w0), 32'd6);
        check_eq("rd3_no_timeout", 32'(tmo_total - t0), 32'd0);

        // Decode error read beyond the last agent
        st0 = tot_stb(); r0 = rdv_total; t0 = tmo_total;
        host_read(16'h5000, acc, dly, rdat);
        repeat (3) @(negedge clk);
        check_eq("dec_accept_lat", 32'(acc), 32'd2);
        check_eq("dec_rdv_delay", 32'(dly), 32'd1);
        check_eq("dec_data", rdat, 32'hDEAD_BEEF);
        check_eq("dec_err_cnt", 32'(err_cnt), 32'd1);
        check_eq("dec_no_strobe", 32'(tot_stb() - st0), 32'd0);
        check_eq("dec_no_timeout", 32'(tmo_total - t0), 32'd0);
        check_eq("dec_rdv_once", 32'(rdv_total - r0), 32'd1);

        // Agent 1 never releases waitrequest: abort after 8 strobe cycles
        stall[1] = 1000;
        w0 = rstb[1]; t0 = tmo_total;
        host_read(16'h1000, acc, dly, rdat);
        repeat (3) @(negedge clk);
        check_eq("fwd_to_accept_lat", 32'(acc), 32'd10);
        check_eq("fwd_to_strobe_cycles", 32'(rstb[1] - w0), 32'd8);
        check_eq("fwd_to_pulse", 32'(tmo_total - t0), 32'd1);
        check_eq("fwd_to_data", rdat, 32'hDEAD_BEEF);
        check_eq("fwd_to_rdv_delay", 32'(dly), 32'd1);
        check_eq("fwd_to_err_cnt", 32'(err_cnt), 32'd2);
        stall[1] = 0;

        // Agent 0 accepts but answers too late: RDV timeout, late data discarded
        lat[0] = 20;
        r0 = rdv_total; t0 = tmo_total;
        host_read(16'h0040, acc, dly, rdat);
        repeat (25) @(negedge clk);
        check_eq("rdv_to_accept_lat", 32'(acc), 32'd3);
        check_eq("rdv_to_rdv_delay", 32'(dly), 32'd9);
        check_eq("rdv_to_data", rdat, 32'hDEAD_BEEF);
        check_eq("rdv_to_pulse", 32'(tmo_total - t0), 32'd1);
        check_eq("rdv_to_late_discard", 32'(rdv_total - r0), 32'd1);
        check_eq("rdv_to_err_cnt", 32'(err_cnt), 32'd3);
        lat[0] = 2;

        // Agent 1 read while agent 0 raises a stray readdatavalid
        lat[1] = 3; rd[1] = 32'h1111_0001;
        r0 = rdv_total;
        fork
            host_read(16'h1008, acc, dly, rdat);
            begin
                @(posedge clk);
                repeat (2) @(posedge clk);
                #1 inj = 4'b0001;
                repeat (2) @(posedge clk);
                #1 inj = 4'b0000;
            end
        join
        repeat (4) @(negedge clk);
        check_eq("stray_accept_lat", 32'(acc), 32'd3);
        check_eq("stray_rdv_delay", 32'(dly), 32'd3);
        check_eq("stray_data", rdat, 32'h1111_0001);
        check_eq("stray_rdv_once", 32'(rdv_total - r0), 32'd1);

        // Decode-error writes drive err_cnt into saturation
        st0 = tot_stb(); r0 = rdv_total;
        for (int i = 0; i < 251; i++) host_write((i % 2 == 0) ? 16'h4000 : 16'hF000, 32'(i), 4'hF, acc);
        @(negedge clk);
        check_eq("sat_err_cnt_fe", 32'(err_cnt), 32'hFE);
        for (int i = 0; i < 49; i++) host_write(16'h8000, 32'(i), 4'hF, acc);
        @(negedge clk);
        check_eq("sat_err_cnt_ff", 32'(err_cnt), 32'hFF);
        check_eq("sat_wr_err_lat", 32'(acc), 32'd2);
        check_eq("sat_no_strobe", 32'(tot_stb() - st0), 32'd0);
        check_eq("sat_no_rdv", 32'(rdv_total - r0), 32'd0);

        // Reset asserted while a write is held in FWD
        stall[2] = 1000;
        @(posedge clk); #1;
        h_address = 16'h2000; h_writedata = 32'h0BAD_0BAD; h_byteenable = 4'hF; h_write = 1'b1;
        @(posedge clk);
        @(posedge clk); #1;
        check_eq("rst_mid_pre_strobe", 32'(a_write), 32'h4);
        #2 reset_n = 1'b0;
        #1;
        check_eq("rst_mid_write", 32'(a_write), 32'h0);
        check_eq("rst_mid_read", 32'(a_read), 32'h0);
        check_eq("rst_mid_waitrequest", 32'(h_waitrequest), 32'h1);
        check_eq("rst_mid_err_cnt", 32'(err_cnt), 32'h0);
        h_write = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        stall[2] = 0;
        r0 = rdv_total;
        host_write(16'h2020, 32'hCAFE_F00D, 4'h3, acc);
        repeat (3) @(negedge clk);
        check_eq("post_rst_accept_lat", 32'(acc), 32'd3);
        check_eq("post_rst_data", wcap_data[2], 32'hCAFE_F00D);
        check_eq("post_rst_addr", wcap_addr[2], 32'h0000_2020);
        check_eq("post_rst_be", 32'(wcap_be[2]), 32'h3);
        check_eq("post_rst_no_rdv", 32'(rdv_total - r0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
